ifetch_responder: RTL and testbench

IFETCH_RESPONDER -- requirements
Module: ifetch_responder

---
 rtl/ifetch_responder.sv | 151 +++++++++++++++
 tb/tb_ifetch_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_responder.sv
// Instruction fetch responder: turns PC-unit fetch requests into single
// outstanding memory reads, queues returned words in a 2-entry FIFO, and
// handles branch flushes, misaligned PCs and memory timeouts.
module ifetch_responder #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] RESET_PC       = 32'h00400020
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    input  logic        flush,
    output logic        advance,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN, FAULT} state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic [1:0]    count;
    logic          rd_ptr;
    logic          wr_ptr;
    logic [31:0]   q_data [2];
    logic [31:0]   q_pc   [2];

    logic pc_aligned;
    logic push;
    logic pop;
    logic flush_q;
    logic timer_expired;

    // A word is accepted only from WAIT; a flush in the ack cycle drops it.
    // Once faulted, flush no longer touches the queue.
    assign pc_aligned    = (pc_in[1:0] == 2'b00);
    assign push          = (state == WAIT) && mem_ack && !flush;
    assign pop           = (count != 2'd0) && instr_ready;
    assign flush_q       = flush && (state != FAULT);
    assign timer_expired = (timer == TW'(TIMEOUT_CYCLES - 1));

    // Fetch control FSM with registered request/advance/fault outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            mem_req  <= 1'b0;
            mem_addr <= 32'h0;
            advance  <= 1'b0;
            fault    <= 1'b0;
        end else begin
            advance <= 1'b0;
            case (state)
                IDLE: begin
                    // Misalignment is checked before queue space
                    if (pc_valid && !pc_aligned) begin
                        state   <= FAULT;
                        fault   <= 1'b1;
                        mem_req <= 1'b0;
                    end else if (pc_valid && (count < 2'd2) && !flush) begin
                        state    <= WAIT;
                        mem_req  <= 1'b1;
                        mem_addr <= pc_in;
                        timer    <= '0;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        advance <= !flush;
                    end else if (flush) begin
                        state <= DRAIN;
                        timer <= '0;
                    end else if (timer_expired) begin
                        state   <= FAULT;
                        fault   <= 1'b1;
                        mem_req <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DRAIN: begin
                    // Keep the request up until the stale word returns
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end else if (timer_expired) begin
                        state   <= FAULT;
                        fault   <= 1'b1;
                        mem_req <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state   <= FAULT;
                    fault   <= 1'b1;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Queue occupancy and pointers; flush wins over push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (flush_q) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage: each entry captures {address, data} when it is the write slot
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr == 1'(gi))) begin
                    q_data[gi] <= mem_rdata;
                    q_pc[gi]   <= mem_addr;
                end
            end
        end
    endgenerate

    assign instr_valid = (count != 2'd0);
    assign instr       = instr_valid ? q_data[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? q_pc[rd_ptr]   : RESET_PC;

endmodule

// File: tb/tb_ifetch_responder.sv
// Bench for ifetch_responder: randomized fetch traffic against a queue-based
// reference model, followed by directed scenarios (basic fetch, backpressure,
// flushes, misalignment, timeout, reset mid-request).
module tb_ifetch_responder;

    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] RST_PC   = 32'h00400020;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        flush;
    logic        advance;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        fault;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [63:0] m_q[$];
    bit          m_busy;
    bit          m_drop;
    bit          m_fault;
    bit          m_adv;
    logic [31:0] m_addr;
    int          m_wait;

    always #5 clk = ~clk;

    ifetch_responder #(.TIMEOUT_CYCLES(TIMEOUT), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_valid(pc_valid),
        .flush(flush), .advance(advance), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .fault(fault)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy  = 0;
        m_drop  = 0;
        m_fault = 0;
        m_adv   = 0;
        m_addr  = 32'h0;
        m_wait  = 0;
    endtask

    // One clock edge of the intended behaviour, from the inputs in force
    task automatic model_step();
        bit pop;
        bit push;
        int sz;
        sz   = m_q.size();
        pop  = (sz != 0) && instr_ready;
        push = 0;
        m_adv = 0;
        if (m_fault) begin
            if (pop) void'(m_q.pop_front());
            return;
        end
        if (!m_busy) begin
            if (pc_valid && pc_in[1:0] != 2'b00) begin
                m_fault = 1;
            end else if (pc_valid && !flush && sz < 2) begin
                m_busy = 1; m_drop = 0; m_addr = pc_in; m_wait = 0;
            end
        end else if (mem_ack) begin
            push   = !m_drop && !flush;
            m_adv  = push;
            m_busy = 0;
        end else if (flush && !m_drop) begin
            m_drop = 1;
            m_wait = 0;
        end else begin
            m_wait++;
            if (m_wait == TIMEOUT) begin
                m_fault = 1;
                m_busy  = 0;
            end
        end
        if (flush) begin
            m_q.delete();
        end else begin
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back({m_addr, mem_rdata});
        end
    endtask

    task automatic check_outputs();
        bit          v;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        v       = (m_q.size() != 0);
        e_instr = v ? m_q[0][31:0]  : 32'h0;
        e_pc    = v ? m_q[0][63:32] : RST_PC;
        check_val("instr_valid", {31'b0, instr_valid}, {31'b0, v});
        check_val("instr",       instr,    e_instr);
        check_val("instr_pc",    instr_pc, e_pc);
        check_val("mem_req",     {31'b0, mem_req}, {31'b0, (m_busy && !m_fault)});
        check_val("mem_addr",    mem_addr, m_addr);
        check_val("advance",     {31'b0, advance}, {31'b0, m_adv});
        check_val("fault",       {31'b0, fault},   {31'b0, m_fault});
    endtask

    // Drive one cycle of inputs (called at a negedge), then check after the edge
    task automatic cycle(input logic v, input logic [31:0] pc, input logic fl,
                         input logic rdy, input logic ack, input logic [31:0] rd);
        pc_valid = v; pc_in = pc; flush = fl; instr_ready = rdy;
        mem_ack = ack; mem_rdata = rd;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_mem_req",  {31'b0, mem_req},     32'h0);
        check_val("rst_mem_addr", mem_addr,             32'h0);
        check_val("rst_advance",  {31'b0, advance},     32'h0);
        check_val("rst_valid",    {31'b0, instr_valid}, 32'h0);
        check_val("rst_instr",    instr,                32'h0);
        check_val("rst_instr_pc", instr_pc,             RST_PC);
        check_val("rst_fault",    {31'b0, fault},       32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit          pend;
        int          lat;
        logic        ack;
        logic [31:0] pc;
        rst_n = 1'b0; pc_in = '0; pc_valid = 0; flush = 0;
        mem_ack = 0; mem_rdata = '0; instr_ready = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Randomized traffic with a memory that answers after 0..5 cycles
        pend = 0; lat = 0;
        for (int i = 0; i < 3000; i++) begin
            if (mem_req && !pend) begin
                pend = 1;
                lat  = $urandom_range(0, 5);
            end
            ack = pend && (lat == 0);
            if (ack) pend = 0;
            else if (pend) lat--;
            pc = $urandom() & 32'hFFFF_FFFC;
            cycle(($urandom_range(0, 9) < 7), pc, ($urandom_range(0, 19) == 0),
                  $urandom_range(0, 1), ack, $urandom());
        end
        $display("[TB] random phase done, %0d checks", n_tests);

        // Basic fetch with ack two cycles after issue
        do_reset();
        cycle(1, 32'h00400020, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 32'h8C010004);
        check_val("basic_advance", {31'b0, advance}, 32'h1);
        check_val("basic_instr",   instr,    32'h8C010004);
        check_val("basic_pc",      instr_pc, 32'h00400020);
        cycle(0, 0, 0, 0, 0, 0);
        check_val("basic_adv_pulse", {31'b0, advance}, 32'h0);
        $display("[TB] basic fetch checked");

        // Backpressure: third fetch waits for a pop
        do_reset();
        cycle(1, 32'h100, 0, 0, 0, 0);
        cycle(1, 32'h104, 0, 0, 1, 32'hA0);
        cycle(1, 32'h104, 0, 0, 0, 0);
        cycle(1, 32'h108, 0, 0, 1, 32'hA1);
        cycle(1, 32'h108, 0, 0, 0, 0);
        check_val("bp_no_issue", {31'b0, mem_req}, 32'h0);
        cycle(1, 32'h108, 0, 1, 0, 0);
        cycle(1, 32'h108, 0, 0, 0, 0);
        check_val("bp_issue", {31'b0, mem_req}, 32'h1);
        check_val("bp_head",  instr_pc, 32'h104);
        cycle(0, 0, 0, 0, 1, 32'hA2);
        $display("[TB] backpressure checked");

        // Misaligned PC with words queued: fault, flush ignored, pops allowed
        cycle(1, 32'h00400022, 0, 0, 0, 0);
        check_val("mis_fault", {31'b0, fault}, 32'h1);
        cycle(1, 32'h200, 1, 0, 0, 0);
        check_val("mis_kept", {31'b0, instr_valid}, 32'h1);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        check_val("mis_sticky", {31'b0, fault}, 32'h1);
        $display("[TB] misaligned fault checked");

        // Flush one cycle after issue, ack three cycles later
        do_reset();
        cycle(1, 32'h300, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check_val("drain_req", {31'b0, mem_req}, 32'h1);
        cycle(0, 0, 0, 0, 1, 32'hDEAD);
        check_val("drain_empty", {31'b0, instr_valid}, 32'h0);

        // Flush and ack in the same cycle drops the word
        cycle(1, 32'h304, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 1, 32'hBEEF);
        check_val("flack_empty", {31'b0, instr_valid}, 32'h0);

        // Push and pop together with one word queued
        cycle(1, 32'h400, 0, 0, 1, 32'h11);
        cycle(0, 0, 0, 0, 1, 32'h11);
        cycle(1, 32'h404, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 32'h22);
        check_val("pp_head", instr_pc, 32'h404);
        cycle(0, 0, 0, 1, 0, 0);
        check_val("pp_count1", {31'b0, instr_valid}, 32'h0);
        $display("[TB] flush and simultaneous events checked");

        // Timeout after TIMEOUT cycles without ack
        do_reset();
        cycle(1, 32'h500, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) cycle(0, 0, 0, 0, 0, 0);
        check_val("to_not_yet", {31'b0, fault}, 32'h0);
        cycle(0, 0, 0, 0, 0, 0);
        check_val("to_fault", {31'b0, fault},   32'h1);
        check_val("to_req",   {31'b0, mem_req}, 32'h0);
        $display("[TB] timeout checked");

        // Reset in the middle of a request, late ack ignored
        do_reset();
        cycle(1, 32'h600, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        do_reset();
        cycle(0, 0, 0, 0, 1, 32'h77);
        check_val("late_ack", {31'b0, instr_valid}, 32'h0);
        check_val("late_adv", {31'b0, advance},     32'h0);
        $display("[TB] reset mid-request checked");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
